// File: rtl/j1_ioport_if.sv
// ---------------------------------------------------------------------------
// j1_ioport_if -- CPU I/O bus between the J1 core and j1_ioport.
//
// Signals:
//   io_rd    : one-cycle read strobe (CPU -> port)
//   io_wr    : one-cycle write strobe (CPU -> port)
//   mem_addr : 16-bit I/O register address (CPU -> port)
//   dout     : 16-bit CPU write data (CPU -> port)
//   io_din   : 16-bit registered read data (port -> CPU)
//
// Modports: master = CPU side, slave = I/O port side.
// ---------------------------------------------------------------------------
interface j1_ioport_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din;

  modport master (
    output io_rd,
    output io_wr,
    output mem_addr,
    output dout,
    input  io_din
  );

  modport slave (
    input  io_rd,
    input  io_wr,
    input  mem_addr,
    input  dout,
    output io_din
  );
endinterface

// File: rtl/j1_ioport.sv
// ---------------------------------------------------------------------------
// j1_ioport -- memory-mapped I/O block for the J1 CPU: LED register, input
// pins, and an 8N1 UART with a receive buffer.
//
// Register map (exact 16-bit decode, unmapped reads return 0):
//   0x0001 LEDS      : R/W, low byte drives leds
//   0x0002 PINS      : R,   synchronized pins
//   0x1000 UART_DATA : W starts TX (dropped while busy), R pops RX byte
//   0x2000 UART_STAT : R {frame_err, overrun, rx_valid, tx_busy}; errors
//                      clear on read
//
// Ports:
//   clk      : system clock, rising edge
//   resetq   : asynchronous active-low reset
//   bus      : j1_ioport_if.slave (io_rd, io_wr, mem_addr, dout, io_din)
//   uart_rx  : asynchronous serial input, idle high
//   uart_tx  : serial output, idle high
//   leds     : LED output register
//   pins     : general-purpose inputs (asynchronous)
//
// Parameter CLKS_PER_BIT: clk cycles per UART bit (>= 4).
// Build option: define J1_IOPORT_RXFIFO_EN for a 4-entry RX FIFO; otherwise
// the RX buffer is a single holding register.
// ---------------------------------------------------------------------------
module j1_ioport #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       resetq,
  j1_ioport_if.slave bus,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] leds,
  input  logic [7:0] pins
);

  localparam logic [15:0] ADDR_LEDS = 16'h0001;
  localparam logic [15:0] ADDR_PINS = 16'h0002;
  localparam logic [15:0] ADDR_DATA = 16'h1000;
  localparam logic [15:0] ADDR_STAT = 16'h2000;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // -------------------------------------------------------------------------
  // Address decode. A simultaneous read and write is treated as a write only:
  // the read has no side effects and io_din keeps its value.
  // -------------------------------------------------------------------------
  logic sel_leds, sel_pins, sel_data, sel_stat;
  logic rd_en, wr_en;
  logic data_rd, stat_rd;

  assign sel_leds = (bus.mem_addr == ADDR_LEDS);
  assign sel_pins = (bus.mem_addr == ADDR_PINS);
  assign sel_data = (bus.mem_addr == ADDR_DATA);
  assign sel_stat = (bus.mem_addr == ADDR_STAT);
  assign wr_en    = bus.io_wr;
  assign rd_en    = bus.io_rd & ~bus.io_wr;
  assign data_rd  = rd_en & sel_data;
  assign stat_rd  = rd_en & sel_stat;

  // Only the low byte of write data is used by any register.
  logic unused_dout_hi;
  assign unused_dout_hi = &{1'b0, bus.dout[15:8]};

  // -------------------------------------------------------------------------
  // LED register
  // -------------------------------------------------------------------------
  logic [7:0] leds_reg;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      leds_reg <= 8'h00;
    end else if (wr_en && sel_leds) begin
      leds_reg <= bus.dout[7:0];
    end
  end

  assign leds = leds_reg;

  // -------------------------------------------------------------------------
  // Input synchronizers. The RX line idles high, so its flops reset to 1 to
  // avoid a false start bit right after reset.
  // -------------------------------------------------------------------------
  logic [7:0] pins_meta_reg, pins_sync_reg;
  logic       rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pins_meta_reg <= 8'h00;
      pins_sync_reg <= 8'h00;
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      rx_prev_reg   <= 1'b1;
    end else begin
      pins_meta_reg <= pins;
      pins_sync_reg <= pins_meta_reg;
      rx_meta_reg   <= uart_rx;
      rx_sync_reg   <= rx_meta_reg;
      rx_prev_reg   <= rx_sync_reg;
    end
  end

  // -------------------------------------------------------------------------
  // UART transmitter. uart_tx and tx_busy are registered and change on the
  // edge that accepts the write.
  // -------------------------------------------------------------------------
  tx_state_t     tx_state_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [2:0]    tx_bit_reg;
  logic [7:0]    tx_shift_reg;
  logic          uart_tx_reg;
  logic          tx_busy_reg;
  logic          tx_start;

  assign tx_start = wr_en & sel_data & (tx_state_reg == TX_IDLE);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'h00;
      uart_tx_reg  <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (tx_start) begin
            tx_state_reg <= TX_START;
            tx_cnt_reg   <= '0;
            tx_shift_reg <= bus.dout[7:0];
            uart_tx_reg  <= 1'b0;
            tx_busy_reg  <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 3'd0;
            tx_state_reg <= TX_DATA;
            uart_tx_reg  <= tx_shift_reg[0];
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 3'd7) begin
              tx_state_reg <= TX_STOP;
              uart_tx_reg  <= 1'b1;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
              uart_tx_reg  <= tx_shift_reg[1];
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= TX_IDLE;
            tx_busy_reg  <= 1'b0;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx = uart_tx_reg;

  // -------------------------------------------------------------------------
  // UART receiver. A falling edge starts a half-bit wait to the start-bit
  // centre; a line that has gone high again by then is a glitch. Data and
  // stop bits are then sampled one bit period apart. rx_done_reg pulses for
  // one cycle with the stop-bit value; the assembled byte stays in
  // rx_shift_reg until the next frame's data bits arrive.
  // -------------------------------------------------------------------------
  rx_state_t     rx_state_reg;
  logic [CW-1:0] rx_cnt_reg;
  logic [2:0]    rx_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic          rx_done_reg;
  logic          rx_stop_ok_reg;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_state_reg   <= RX_IDLE;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= 3'd0;
      rx_shift_reg   <= 8'h00;
      rx_done_reg    <= 1'b0;
      rx_stop_ok_reg <= 1'b0;
    end else begin
      rx_done_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg <= '0;
            rx_bit_reg <= 3'd0;
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= RX_STOP;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg     <= '0;
            rx_state_reg   <= RX_IDLE;
            rx_done_reg    <= 1'b1;
            rx_stop_ok_reg <= rx_sync_reg;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // RX buffer. Fullness is judged before any same-cycle pop, so a byte that
  // lands on a full buffer is an overrun even if the CPU is reading it.
  // -------------------------------------------------------------------------
  logic       buf_full, buf_empty;
  logic [7:0] buf_head;
  logic       buf_push, buf_pop;
  logic       rx_valid;

  assign buf_push = rx_done_reg & rx_stop_ok_reg & ~buf_full;
  assign buf_pop  = data_rd & ~buf_empty;
  assign rx_valid = ~buf_empty;

`ifdef J1_IOPORT_RXFIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] count_reg;

  always_ff @(posedge clk) begin
    if (buf_push) begin
      fifo_mem[wr_ptr_reg] <= rx_shift_reg;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (buf_push) begin
        wr_ptr_reg <= wr_ptr_reg + 2'd1;
      end
      if (buf_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      end
      case ({buf_push, buf_pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign buf_full  = (count_reg == 3'd4);
  assign buf_empty = (count_reg == 3'd0);
  assign buf_head  = fifo_mem[rd_ptr_reg];
`else
  logic [7:0] hold_reg;
  logic       hold_valid_reg;

  // Push requires an empty holder and pop a full one, so they never coincide.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      hold_reg       <= 8'h00;
      hold_valid_reg <= 1'b0;
    end else if (buf_push) begin
      hold_reg       <= rx_shift_reg;
      hold_valid_reg <= 1'b1;
    end else if (buf_pop) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign buf_full  = hold_valid_reg;
  assign buf_empty = ~hold_valid_reg;
  assign buf_head  = hold_reg;
`endif

  // -------------------------------------------------------------------------
  // Sticky error flags: cleared by a STAT read, but a new error arriving on
  // the same edge wins.
  // -------------------------------------------------------------------------
  logic overrun_reg, frame_err_reg;
  logic overrun_set, frame_err_set;

  assign overrun_set   = rx_done_reg & rx_stop_ok_reg & buf_full;
  assign frame_err_set = rx_done_reg & ~rx_stop_ok_reg;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (stat_rd) begin
        overrun_reg <= 1'b0;
      end
      if (frame_err_set) begin
        frame_err_reg <= 1'b1;
      end else if (stat_rd) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read-data register: loaded only on a read strobe, held otherwise.
  // -------------------------------------------------------------------------
  logic [15:0] rd_data;
  logic [15:0] io_din_reg;

  always_comb begin
    rd_data = 16'h0000;
    if (sel_leds) begin
      rd_data = {8'h00, leds_reg};
    end else if (sel_pins) begin
      rd_data = {8'h00, pins_sync_reg};
    end else if (sel_data) begin
      rd_data = buf_empty ? 16'h0000 : {8'h00, buf_head};
    end else if (sel_stat) begin
      rd_data = {12'h000, frame_err_reg, overrun_reg, rx_valid, tx_busy_reg};
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      io_din_reg <= 16'h0000;
    end else if (rd_en) begin
      io_din_reg <= rd_data;
    end
  end

  assign bus.io_din = io_din_reg;

endmodule

// File: tb/tb_j1_ioport.sv
`timescale 1ns/1ps
module tb_j1_ioport;

  localparam int CPB = 8;
`ifdef J1_IOPORT_RXFIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] leds;
  logic [7:0] pins = 8'h00;

  j1_ioport_if bus ();

  j1_ioport #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .bus     (bus),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .leds    (leds),
    .pins    (pins)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: RX buffer contents, sticky flags, LED value.
  logic [7:0] rx_q[$];
  logic       m_ovr = 1'b0;
  logic       m_fe  = 1'b0;
  logic [7:0] m_leds = 8'h00;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_RW} op_t;
  typedef struct {
    op_t         op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  pins;
    logic [15:0] exp_din;
    logic [7:0]  exp_leds;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    bus.mem_addr = a;
    bus.dout     = d;
    bus.io_wr    = 1'b1;
    @(negedge clk);
    bus.io_wr    = 1'b0;
    $display("wr   addr=0x%04h data=0x%04h", a, d);
  endtask

  task automatic io_read(input logic [15:0] a, output logic [15:0] d);
    bus.mem_addr = a;
    bus.io_rd    = 1'b1;
    @(negedge clk);
    bus.io_rd    = 1'b0;
    d = bus.io_din;
    $display("rd   addr=0x%04h data=0x%04h", a, d);
  endtask

  // Drive one 8N1 frame followed by one idle bit, then update the model.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick(CPB);
    end
    uart_rx = 1'b1;
    tick(CPB);
    if (!stop) m_fe = 1'b1;
    else if (rx_q.size() >= RX_DEPTH) m_ovr = 1'b1;
    else rx_q.push_back(b);
    $display("rx   frame byte=0x%02h stop=%0d", b, stop);
  endtask

  task automatic rd_data_chk(input string name);
    logic [15:0] got, exp;
    exp = (rx_q.size() != 0) ? {8'h00, rx_q.pop_front()} : 16'h0000;
    io_read(16'h1000, got);
    check(name, got, exp);
  endtask

  task automatic rd_stat_chk(input string name, input logic busy);
    logic [15:0] got, exp;
    exp = {12'h000, m_fe, m_ovr, (rx_q.size() != 0), busy};
    io_read(16'h2000, got);
    check(name, got, exp);
    m_fe  = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] got;
    logic [9:0]  frame;
    logic        is_rd;

    bus.io_rd    = 1'b0;
    bus.io_wr    = 1'b0;
    bus.mem_addr = 16'h0000;
    bus.dout     = 16'h0000;

    // ---------------- reset state ----------------
    tick(3);
    check("rst_io_din", bus.io_din, 16'h0000);
    check("rst_leds", {8'h00, leds}, 16'h0000);
    check("rst_uart_tx", {15'h0, uart_tx}, 16'h0001);
    resetq = 1'b1;
    tick(2);

    // ---------------- register table ----------------
    vecs.push_back('{OP_RD, 16'h0001, 16'h0000, 8'h00, 16'h0000, 8'h00});
    vecs.push_back('{OP_WR, 16'h0001, 16'h00A5, 8'h00, 16'h0000, 8'hA5});
    vecs.push_back('{OP_RD, 16'h0001, 16'h0000, 8'h00, 16'h00A5, 8'hA5});
    vecs.push_back('{OP_RD, 16'h0003, 16'h0000, 8'h00, 16'h0000, 8'hA5});
    vecs.push_back('{OP_WR, 16'h0101, 16'h00FF, 8'h00, 16'h0000, 8'hA5});
    vecs.push_back('{OP_RD, 16'h0001, 16'h0000, 8'h00, 16'h00A5, 8'hA5});
    vecs.push_back('{OP_RD, 16'h0002, 16'h0000, 8'h5A, 16'h005A, 8'hA5});
    vecs.push_back('{OP_WR, 16'h0000, 16'h0011, 8'h5A, 16'h005A, 8'hA5});
    vecs.push_back('{OP_RD, 16'h2000, 16'h0000, 8'h5A, 16'h0000, 8'hA5});
    vecs.push_back('{OP_RD, 16'h1000, 16'h0000, 8'h5A, 16'h0000, 8'hA5});
    vecs.push_back('{OP_RD, 16'h0002, 16'h0000, 8'hC3, 16'h00C3, 8'hA5});
    vecs.push_back('{OP_RW, 16'h0001, 16'h003C, 8'hC3, 16'h00C3, 8'h3C});
    vecs.push_back('{OP_RD, 16'h0001, 16'h0000, 8'hC3, 16'h003C, 8'h3C});
    vecs.push_back('{OP_WR, 16'h0001, 16'h1234, 8'hC3, 16'h003C, 8'h34});
    vecs.push_back('{OP_RD, 16'h0001, 16'h0000, 8'hC3, 16'h0034, 8'h34});
    vecs.push_back('{OP_RD, 16'h0201, 16'h0000, 8'hC3, 16'h0000, 8'h34});

    foreach (vecs[k]) begin
      pins = vecs[k].pins;
      tick(3);
      case (vecs[k].op)
        OP_WR: io_write(vecs[k].addr, vecs[k].data);
        OP_RD: io_read(vecs[k].addr, got);
        default: begin
          bus.mem_addr = vecs[k].addr;
          bus.dout     = vecs[k].data;
          bus.io_rd    = 1'b1;
          bus.io_wr    = 1'b1;
          @(negedge clk);
          bus.io_rd    = 1'b0;
          bus.io_wr    = 1'b0;
          $display("rdwr addr=0x%04h data=0x%04h", vecs[k].addr, vecs[k].data);
        end
      endcase
      check("vec_io_din", bus.io_din, vecs[k].exp_din);
      check("vec_leds", {8'h00, leds}, {8'h00, vecs[k].exp_leds});
      tick(2);
      check("vec_io_din_hold", bus.io_din, vecs[k].exp_din);
    end
    m_leds = 8'h34;

    // ---------------- single RX byte ----------------
    send_frame(8'h3C, 1'b1);
    rd_stat_chk("rx_stat_valid", 1'b0);
    rd_data_chk("rx_data_3c");
    rd_stat_chk("rx_stat_empty", 1'b0);

    // ---------------- overrun: five bytes, no reads ----------------
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    for (int r = 0; r < 5; r++) rd_data_chk("ovr_data");
    rd_stat_chk("ovr_stat", 1'b0);
    rd_stat_chk("ovr_stat_cleared", 1'b0);

    // ---------------- frame error and glitch ----------------
    send_frame(8'h81, 1'b0);
    rd_stat_chk("ferr_stat", 1'b0);
    rd_stat_chk("ferr_stat_cleared", 1'b0);
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(3 * CPB);
    rd_stat_chk("glitch_stat", 1'b0);
    rd_data_chk("glitch_data");

    // ---------------- TX frame 0x55 ----------------
    frame = {1'b1, 8'h55, 1'b0};
    io_write(16'h1000, 16'h0055);
    for (int i = 0; i < 10 * CPB; i++) begin
      check("tx_bit", {15'h0, uart_tx}, {15'h0, frame[i / CPB]});
      is_rd = (i == 0) || (i == 5 * CPB + 2) || (i == 10 * CPB - 1);
      bus.io_wr = 1'b0;
      bus.io_rd = 1'b0;
      if (i == 3 * CPB + 2) begin
        bus.mem_addr = 16'h1000;
        bus.dout     = 16'h00FF;
        bus.io_wr    = 1'b1;
        $display("wr   addr=0x1000 data=0x00FF (during frame)");
      end else if (is_rd) begin
        bus.mem_addr = 16'h2000;
        bus.io_rd    = 1'b1;
      end
      @(negedge clk);
      bus.io_wr = 1'b0;
      bus.io_rd = 1'b0;
      if (is_rd) begin
        $display("rd   addr=0x2000 data=0x%04h (during frame)", bus.io_din);
        check("tx_stat_busy", bus.io_din, 16'h0001);
      end
    end
    rd_stat_chk("tx_stat_done", 1'b0);
    for (int i = 0; i < 12 * CPB; i++) begin
      check("tx_idle_after", {15'h0, uart_tx}, 16'h0001);
      tick(1);
    end

    // ---------------- randomized mix against the model ----------------
    for (int k = 0; k < 30; k++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      case ($urandom_range(0, 5))
        0: send_frame(rb, ($urandom_range(0, 4) != 0));
        1: rd_data_chk("rnd_data");
        2: rd_stat_chk("rnd_stat", 1'b0);
        3: begin
          io_write(16'h0001, {8'($urandom), rb});
          m_leds = rb;
          check("rnd_leds_port", {8'h00, leds}, {8'h00, m_leds});
        end
        4: begin
          io_read(16'h0001, got);
          check("rnd_leds_rd", got, {8'h00, m_leds});
        end
        default: begin
          pins = rb;
          tick(3);
          io_read(16'h0002, got);
          check("rnd_pins", got, {8'h00, rb});
        end
      endcase
    end
    // Drain so the reset test starts from known state.
    for (int r = 0; r < RX_DEPTH; r++) rd_data_chk("rnd_drain");
    rd_stat_chk("rnd_final_stat", 1'b0);

    // ---------------- reset in the middle of a TX frame ----------------
    io_write(16'h1000, 16'h00A5);
    tick(2 * CPB + CPB / 2);
    check("rst_mid_tx_low", {15'h0, uart_tx}, 16'h0000);
    #2;
    resetq = 1'b0;
    #1;
    check("rst_async_tx", {15'h0, uart_tx}, 16'h0001);
    check("rst_async_leds", {8'h00, leds}, 16'h0000);
    check("rst_async_din", bus.io_din, 16'h0000);
    tick(2);
    resetq = 1'b1;
    rx_q.delete();
    m_fe   = 1'b0;
    m_ovr  = 1'b0;
    m_leds = 8'h00;
    for (int i = 0; i < 11 * CPB; i++) begin
      check("rst_tx_idle", {15'h0, uart_tx}, 16'h0001);
      tick(1);
    end
    rd_stat_chk("rst_stat", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
